// File: rtl/constant_time_divider.sv
// Unsigned restoring divider: one quotient bit per clock, fixed 2*NUM_BITS-cycle latency regardless of operands.
// Results and done appear 2*NUM_BITS edges after start is accepted; start is ignored (not queued) unless idle.
module constant_time_divider #(
    parameter int NUM_BITS = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2*NUM_BITS-1:0]   dividend,
    input  logic [NUM_BITS-1:0]     divisor,
    output logic [2*NUM_BITS-1:0]   quotient,
    output logic [NUM_BITS-1:0]     remainder,
    output logic                    busy,
    output logic                    done,
    output logic                    div_by_zero
);

    localparam int DW = 2 * NUM_BITS;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [DW-1:0]        dvd_q;
    logic [NUM_BITS-1:0]  dsr_q;
    logic [NUM_BITS:0]    rem_q;
    logic [CW-1:0]        cnt;

    logic [NUM_BITS:0]    shifted;
    logic [NUM_BITS+1:0]  trial;
    logic                 take;
    logic [NUM_BITS:0]    rem_next;
    logic [DW-1:0]        dvd_next;
    logic                 last_step;
    logic                 unused_rem_msb;

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    assign shifted   = {rem_q[NUM_BITS-1:0], dvd_q[DW-1]};
    assign trial     = {1'b0, shifted} - {2'b00, dsr_q};
    assign take      = ~trial[NUM_BITS+1];
    assign rem_next  = take ? trial[NUM_BITS:0] : shifted;
    assign dvd_next  = {dvd_q[DW-2:0], take};
    assign last_step = (cnt == CW'(DW - 1));

    // Before each shift the remainder is below the divisor, so its top bit
    // only carries information across the subtract, never into the next shift.
    assign unused_rem_msb = rem_q[NUM_BITS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_q <= dividend;
                        dsr_q <= divisor;
                        rem_q <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    dvd_q <= dvd_next;
                    rem_q <= rem_next;
                    cnt   <= cnt + CW'(1);
                    if (last_step) begin
                        quotient    <= dvd_next;
                        remainder   <= rem_next[NUM_BITS-1:0];
                        div_by_zero <= (dsr_q == '0);
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/constant_time_divider.md
Name: constant_time_divider

Overview:
- Sequential restoring divider: the inverse-direction companion to the constant-time shift-add multiplier.
- Divides a 2*NUM_BITS dividend by a NUM_BITS divisor and returns a 2*NUM_BITS quotient and a NUM_BITS remainder.
- Latency is fixed, independent of operand values, including zero and divide-by-zero.
- Sits beside the multiplier in the arithmetic datapath, so a product can be fed straight back in for checking.

Parameters:
- NUM_BITS, 7, divisor/remainder width; dividend and quotient are 2*NUM_BITS wide.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled only in IDLE.
- dividend  input  2*NUM_BITS  numerator, unsigned.
- divisor  input  NUM_BITS  denominator, unsigned.
- quotient  output  2*NUM_BITS  registered result.
- remainder  output  NUM_BITS  registered result.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when results become valid.
- div_by_zero  output  1  registered flag, valid with done.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state=IDLE, step counter=0.
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
  - Reset mid-division abandons the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: latch dividend and divisor, clear the working remainder (NUM_BITS+1 bits), clear the counter, go to RUN.
  - start=0: stay in IDLE.
- RUN: one restoring step per edge.
  - Shift the working remainder left by one, shifting in the dividend MSB; shift the dividend register left.
  - Compute trial = working remainder - {1'b0, divisor}.
  - If trial is non-negative: working remainder = trial, quotient bit = 1. Otherwise keep the shifted remainder, quotient bit = 0.
  - Both paths are always computed and selected by mux. No early exit, no skipping leading zeros, no operand-dependent cycle count.
  - Counter increments each step. On the edge that completes step 2*NUM_BITS: load quotient, remainder and div_by_zero output registers, go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - Unconditionally return to IDLE on the next edge.
- Latency: the start-accepting edge is E0. Results and done are visible after edge E(2*NUM_BITS), i.e. 14 edges later for NUM_BITS=7. done is low again after E(2*NUM_BITS+1).
- Outputs hold their values after DONE until the next operation's DONE-loading edge or reset. They are not cleared on start.
- start while in RUN or DONE is ignored; it is not queued.
- Operand input changes after E0 have no effect (operands are latched).
- Divide-by-zero (divisor=0):
  - Same latency.
  - quotient = all ones; remainder = dividend[NUM_BITS-1:0]; div_by_zero=1.
  - This equals the natural restoring-algorithm result; no special timing path.
- Width rules:
  - Unsigned only.
  - Working remainder is NUM_BITS+1 bits so the subtraction borrow is visible.
  - The final remainder is always < divisor (divisor != 0) and fits in NUM_BITS bits.
  - The quotient cannot overflow 2*NUM_BITS bits.
- div_by_zero clears to 0 on the next non-zero-divisor completion.

Test Plan (NUM_BITS=7):
- Basic division: reset, start with dividend=225, divisor=15 → quotient=15, remainder=0, done high exactly 14 clocks after the start edge; repeat with 6900/75 → 92 r0 and 3276/78 → 42 r0, with identical cycle count each time.
- Zero and maximum operands: 0/12 → 0 r0; 1000/7 → 142 r6; 16383/127 → 129 r0; 16383/1 → 16383 r0; every case completes in 14 clocks (constant time).
- Divide-by-zero: 1000/0 → quotient=16383, remainder=104, div_by_zero=1 on the same 14-clock schedule; a following 10/3 → 3 r1 with div_by_zero=0.
- Handshake: hold start=1 continuously → busy high for 14 cycles, single done pulse, new operation accepted only from IDLE (one IDLE cycle between operations); change operand inputs mid-RUN → result matches the latched operands.
- Reset mid-operation: drive rst=0 asynchronously between clock edges during RUN step 5 → all outputs 0 immediately without a clock edge, no done pulse; after release, 92*75=6900 divided by 92 gives 75 r0.
- Result hold: after DONE, idle 20 cycles with changing inputs and start=0 → quotient, remainder and div_by_zero unchanged, done stays 0.
